// File: rtl/game_period_sequencer.sv
// Game period sequencer: run/pause/buzz/break flow across regulation periods.
// Optional overtime periods are enabled with the OVERTIME_EN macro.
module game_period_sequencer #(
  parameter int BREAK_SEC = 120,
  parameter int HALF_SEC  = 600,
  parameter int BUZZ_SEC  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_go,
  input  logic       clock_zero,
  input  logic       score_tie,
  output logic       clock_run,
  output logic       clock_load,
  output logic       team_swap,
  output logic [2:0] period,
  output logic [2:0] state,
  output logic       buzzer,
  output logic [9:0] break_left
);

  // state   | meaning
  // S_IDLE  | waiting for btn_go to start the period
  // S_RUN   | game clock counting down
  // S_PAUSE | game clock stopped by btn_go
  // S_BUZZ  | end-of-period buzzer, BUZZ_SEC ticks
  // S_BREAK | inter-period or halftime break countdown
  // S_OVER  | game finished, only reset leaves
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_BUZZ  = 3'd3,
    S_BREAK = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam int BUZZ_W = (BUZZ_SEC > 1) ? $clog2(BUZZ_SEC + 1) : 1;

  state_t            state_q, state_n;
  logic [2:0]        period_n;
  logic [9:0]        break_n;
  logic [BUZZ_W-1:0] buzz_cnt_q, buzz_cnt_n;
  logic              load_n, swap_n;
  logic              buzz_done;
  logic              break_done;

`ifndef OVERTIME_EN
  logic unused_score_tie;
  assign unused_score_tie = score_tie;
`endif

  assign buzz_done  = tick_1hz && (buzz_cnt_q <= BUZZ_W'(1));
  assign break_done = btn_go || (tick_1hz && (break_left <= 10'd1));
  assign state      = state_q;

  always_comb begin
    state_n    = state_q;
    period_n   = period;
    break_n    = break_left;
    buzz_cnt_n = buzz_cnt_q;
    load_n     = 1'b0;
    swap_n     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_go) state_n = S_RUN;
      end
      S_RUN: begin
        if (clock_zero) begin
          state_n    = S_BUZZ;
          buzz_cnt_n = BUZZ_W'(BUZZ_SEC);
        end else if (btn_go) begin
          state_n = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_go) state_n = S_RUN;
      end
      S_BUZZ: begin
        if (buzz_done) begin
          buzz_cnt_n = '0;
          if (period < 3'd4) begin
            state_n = S_BREAK;
            break_n = (period == 3'd2) ? 10'(HALF_SEC) : 10'(BREAK_SEC);
          end else begin
`ifdef OVERTIME_EN
            if (score_tie && (period < 3'd7)) begin
              state_n = S_BREAK;
              break_n = 10'(BREAK_SEC);
            end else begin
              state_n = S_OVER;
            end
`else
            state_n = S_OVER;
`endif
          end
        end else if (tick_1hz) begin
          buzz_cnt_n = buzz_cnt_q - BUZZ_W'(1);
        end
      end
      S_BREAK: begin
        // Skip and final tick share one exit path, so a coincident pair exits once.
        if (break_done) begin
          state_n  = S_IDLE;
          break_n  = '0;
          period_n = (period == 3'd7) ? 3'd7 : period + 3'd1;
          load_n   = 1'b1;
          swap_n   = (period == 3'd2);
        end else if (tick_1hz && (break_left != 10'd0)) begin
          break_n = break_left - 10'd1;
        end
      end
      S_OVER: begin
        state_n = S_OVER;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      period     <= 3'd1;
      break_left <= '0;
      buzz_cnt_q <= '0;
      clock_run  <= 1'b0;
      clock_load <= 1'b0;
      team_swap  <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state_q    <= state_n;
      period     <= period_n;
      break_left <= break_n;
      buzz_cnt_q <= buzz_cnt_n;
      clock_run  <= (state_n == S_RUN);
      clock_load <= load_n;
      team_swap  <= swap_n;
      buzzer     <= (state_n == S_BUZZ);
    end
  end

endmodule

// File: tb/tb_game_period_sequencer.sv
// Vector-table bench for game_period_sequencer (BREAK_SEC=3, HALF_SEC=5, BUZZ_SEC=2).
module tb_game_period_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, btn_go, clock_zero, score_tie;
  logic       clock_run, clock_load, team_swap, buzzer;
  logic [2:0] period, state;
  logic [9:0] break_left;

  game_period_sequencer #(.BREAK_SEC(3), .HALF_SEC(5), .BUZZ_SEC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .btn_go     (btn_go),
    .clock_zero (clock_zero),
    .score_tie  (score_tie),
    .clock_run  (clock_run),
    .clock_load (clock_load),
    .team_swap  (team_swap),
    .period     (period),
    .state      (state),
    .buzzer     (buzzer),
    .break_left (break_left)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       btn, tick, cz, tie;
    logic [2:0] st, per;
    logic       run, ld, sw, bz;
    logic [9:0] bl;
  } vec_t;

  vec_t        tbl[$];
  logic [19:0] sb_q[$];
  int          checks = 0;
  int          passed = 0;

  function automatic vec_t v(input logic b, t, z, tie, input logic [2:0] st, per,
                             input logic run, ld, sw, bz, input logic [9:0] bl);
    vec_t x;
    x.btn = b; x.tick = t; x.cz = z; x.tie = tie;
    x.st = st; x.per = per; x.run = run; x.ld = ld; x.sw = sw; x.bz = bz; x.bl = bl;
    return x;
  endfunction

  function automatic logic [19:0] pack_exp(input vec_t x);
    return {x.st, x.per, x.run, x.ld, x.sw, x.bz, x.bl};
  endfunction

  task automatic check(input logic [19:0] exp, input string name, input int idx);
    logic [19:0] got;
    got = {state, period, clock_run, clock_load, team_swap, buzzer, break_left};
    checks++;
    if (got === exp) passed++;
    else
      $display("FAIL %s[%0d]: got st=%0d per=%0d run=%b ld=%b sw=%b bz=%b bl=%0d, expected st=%0d per=%0d run=%b ld=%b sw=%b bz=%b bl=%0d",
               name, idx, got[19:17], got[16:14], got[13], got[12], got[11], got[10], got[9:0],
               exp[19:17], exp[16:14], exp[13], exp[12], exp[11], exp[10], exp[9:0]);
  endtask

  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      btn_go = tbl[i].btn; tick_1hz = tbl[i].tick;
      clock_zero = tbl[i].cz; score_tie = tbl[i].tie;
      sb_q.push_back(pack_exp(tbl[i]));
      @(posedge clk);
      #1;
      check(sb_q.pop_front(), name, i);
    end
    @(negedge clk);
    btn_go = 0; tick_1hz = 0; clock_zero = 0; score_tie = 0;
    tbl.delete();
  endtask

  initial begin
    reset = 1'b0; btn_go = 0; tick_1hz = 0; clock_zero = 0; score_tie = 0;
    repeat (3) @(posedge clk);
    #1;
    check({3'd0, 3'd1, 4'b0000, 10'd0}, "reset_hold", 0);
    @(negedge clk);
    reset = 1'b1;

    // Full game flow: btn/pause, buzz, breaks, halftime swap, coincident skip, period 4 end.
    //              btn tick cz tie  st per run ld sw bz bl
    tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 9; k++)
      tbl.push_back(v(0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 0, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 1, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,  4, 1, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,  4, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,  4, 1, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0,  0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 1, 0,  1, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,  3, 2, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 2, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 5));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 4));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 0,  0, 3, 0, 1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 3, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,  3, 3, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 3, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 3, 0, 0, 0, 0, 3));
    tbl.push_back(v(1, 1, 0, 0,  0, 4, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 1,  1, 4, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 1,  3, 4, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 1,  3, 4, 0, 0, 0, 1, 0));
`ifdef OVERTIME_EN
    tbl.push_back(v(0, 1, 0, 1,  4, 4, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, 1, 0, 1,  4, 4, 0, 0, 0, 0, 2));
    tbl.push_back(v(0, 1, 0, 1,  4, 4, 0, 0, 0, 0, 1));
    tbl.push_back(v(0, 1, 0, 1,  0, 5, 0, 1, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 5, 0, 0, 0, 0, 0));
`else
    tbl.push_back(v(0, 1, 0, 1,  5, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  5, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1,  5, 4, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 0, 0,  5, 4, 0, 0, 0, 0, 0));
`endif
    run_tbl("game");

    // Reach period 3 with break_left=2 via skipped breaks, then reset mid-break.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 1, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 1, 0, 0, 0, 0, 3));
    tbl.push_back(v(1, 0, 0, 0,  0, 2, 0, 1, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  1, 2, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,  3, 2, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 2, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 2, 0, 0, 0, 0, 5));
    tbl.push_back(v(1, 0, 0, 0,  0, 3, 0, 1, 1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  1, 3, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0,  3, 3, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  3, 3, 0, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 0, 0,  4, 3, 0, 0, 0, 0, 3));
    tbl.push_back(v(0, 1, 0, 0,  4, 3, 0, 0, 0, 0, 2));
    run_tbl("to_p3");

    #3;
    reset = 1'b0;
    #1;
    check({3'd0, 3'd1, 4'b0000, 10'd0}, "reset_async", 0);
    @(posedge clk);
    #1;
    check({3'd0, 3'd1, 4'b0000, 10'd0}, "reset_held", 0);
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back(v(0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0));
    run_tbl("post_reset");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
